// File: rtl/csr_trap_sequencer.sv
// csr_trap_sequencer: arbitrates the single CSR bank port between the decoded
// CSR-instruction path and the trap-entry write sequence
// (mepc, mcause, optional mtval, then mstatus.MIE clear).
// The trap path has priority; instructions are stalled while a sequence runs.
module csr_trap_sequencer #(
    parameter bit          WRITE_TVAL = 1'b1,
    parameter logic [31:0] MIE_MASK   = 32'h8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        instr_valid_i,
    input  logic        instr_read_i,
    input  logic        instr_write_i,
    input  logic [1:0]  instr_op_i,
    input  logic [11:0] instr_addr_i,
    input  logic [31:0] instr_data_i,
    output logic        instr_ready_o,
    output logic [31:0] instr_rdata_o,
    input  logic        trap_req_i,
    input  logic [31:0] trap_pc_i,
    input  logic [31:0] trap_cause_i,
    input  logic [31:0] trap_tval_i,
    output logic        trap_ack_o,
    output logic        busy_o,
    output logic        csr_read_o,
    output logic        csr_write_o,
    output logic [1:0]  csr_op_o,
    output logic [11:0] csr_addr_o,
    output logic [31:0] csr_data_o,
    input  logic [31:0] csr_rdata_i
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        T_EPC    = 3'd1,
        T_CAUSE  = 3'd2,
        T_TVAL   = 3'd3,
        T_STATUS = 3'd4
    } state_t;

    localparam logic [1:0]  OP_NONE    = 2'd0;
    localparam logic [1:0]  OP_WRITE   = 2'd1;
    localparam logic [1:0]  OP_CLEAR   = 2'd3;
    localparam logic [11:0] ADDR_MSTAT = 12'h300;
    localparam logic [11:0] ADDR_MEPC  = 12'h341;
    localparam logic [11:0] ADDR_MCAUS = 12'h342;
    localparam logic [11:0] ADDR_MTVAL = 12'h343;

    state_t      state_reg;
    state_t      state_next;
    logic        trap_accept;
    logic [31:0] payload_in [3];
    logic [31:0] payload_reg [3];   // 0: pc, 1: cause, 2: tval

    // A trap is only accepted from IDLE; requests while busy are ignored.
    assign trap_accept   = (state_reg == IDLE) && trap_req_i;
    assign payload_in[0] = trap_pc_i;
    assign payload_in[1] = trap_cause_i;
    assign payload_in[2] = trap_tval_i;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Trap payload words are captured once at acceptance so that later
    // changes on the trap inputs cannot corrupt the sequence in flight.
    for (genvar gi = 0; gi < 3; gi++) begin : g_payload
        // Capture one payload word on trap acceptance.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                payload_reg[gi] <= '0;
            end else if (trap_accept) begin
                payload_reg[gi] <= payload_in[gi];
            end
        end
    end

    // Next-state logic and bank-port multiplexing.
    always_comb begin
        state_next    = state_reg;
        instr_ready_o = 1'b0;
        instr_rdata_o = '0;
        trap_ack_o    = 1'b0;
        busy_o        = 1'b0;
        csr_read_o    = 1'b0;
        csr_write_o   = 1'b0;
        csr_op_o      = OP_NONE;
        csr_addr_o    = '0;
        csr_data_o    = '0;

        case (state_reg)
            IDLE: begin
                if (trap_req_i) begin
                    // Acceptance cycle: no bank access, instruction held off.
                    state_next = T_EPC;
                end else if (instr_valid_i) begin
                    instr_ready_o = 1'b1;
                    instr_rdata_o = csr_rdata_i;
                    // Without read or write enable the port stays idle.
                    if (instr_read_i || instr_write_i) begin
                        csr_read_o  = instr_read_i;
                        csr_write_o = instr_write_i;
                        csr_op_o    = instr_op_i;
                        csr_addr_o  = instr_addr_i;
                        csr_data_o  = instr_data_i;
                    end
                end
            end
            T_EPC: begin
                busy_o      = 1'b1;
                csr_write_o = 1'b1;
                csr_op_o    = OP_WRITE;
                csr_addr_o  = ADDR_MEPC;
                csr_data_o  = payload_reg[0];
                state_next  = T_CAUSE;
            end
            T_CAUSE: begin
                busy_o      = 1'b1;
                csr_write_o = 1'b1;
                csr_op_o    = OP_WRITE;
                csr_addr_o  = ADDR_MCAUS;
                csr_data_o  = payload_reg[1];
                state_next  = WRITE_TVAL ? T_TVAL : T_STATUS;
            end
            T_TVAL: begin
                busy_o      = 1'b1;
                csr_write_o = 1'b1;
                csr_op_o    = OP_WRITE;
                csr_addr_o  = ADDR_MTVAL;
                csr_data_o  = payload_reg[2];
                state_next  = T_STATUS;
            end
            T_STATUS: begin
                busy_o      = 1'b1;
                csr_write_o = 1'b1;
                csr_op_o    = OP_CLEAR;
                csr_addr_o  = ADDR_MSTAT;
                csr_data_o  = MIE_MASK;
                trap_ack_o  = 1'b1;
                state_next  = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Keep every output quiet while reset is held.
        if (!reset_n) begin
            instr_ready_o = 1'b0;
            instr_rdata_o = '0;
            trap_ack_o    = 1'b0;
            busy_o        = 1'b0;
            csr_read_o    = 1'b0;
            csr_write_o   = 1'b0;
            csr_op_o      = OP_NONE;
            csr_addr_o    = '0;
            csr_data_o    = '0;
        end
    end

endmodule

// File: tb/tb_csr_trap_sequencer.sv
// tb_csr_trap_sequencer: drives two instances (with and without the mtval
// step) from shared stimulus. A reference model turns each cycle's inputs
// into the expected port observation and queues it; a negedge monitor pops
// and compares against what each instance presents.
module tb_csr_trap_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        instr_valid_i = 1'b0, instr_read_i = 1'b0, instr_write_i = 1'b0;
    logic [1:0]  instr_op_i = '0;
    logic [11:0] instr_addr_i = '0;
    logic [31:0] instr_data_i = '0;
    logic        trap_req_i = 1'b0;
    logic [31:0] trap_pc_i = '0, trap_cause_i = '0, trap_tval_i = '0;
    logic [31:0] csr_rdata_i = '0;

    logic        rdy1, ack1, busy1, rd1, wr1, rdy0, ack0, busy0, rd0, wr0;
    logic [31:0] rdata1, data1, rdata0, data0;
    logic [1:0]  op1, op0;
    logic [11:0] addr1, addr0;

    always #5 clk = ~clk;

    csr_trap_sequencer #(.WRITE_TVAL(1'b1), .MIE_MASK(32'h8)) dut_tv1 (
        .clk(clk), .reset_n(reset_n),
        .instr_valid_i(instr_valid_i), .instr_read_i(instr_read_i),
        .instr_write_i(instr_write_i), .instr_op_i(instr_op_i),
        .instr_addr_i(instr_addr_i), .instr_data_i(instr_data_i),
        .instr_ready_o(rdy1), .instr_rdata_o(rdata1),
        .trap_req_i(trap_req_i), .trap_pc_i(trap_pc_i),
        .trap_cause_i(trap_cause_i), .trap_tval_i(trap_tval_i),
        .trap_ack_o(ack1), .busy_o(busy1),
        .csr_read_o(rd1), .csr_write_o(wr1), .csr_op_o(op1),
        .csr_addr_o(addr1), .csr_data_o(data1), .csr_rdata_i(csr_rdata_i)
    );

    csr_trap_sequencer #(.WRITE_TVAL(1'b0), .MIE_MASK(32'h8)) dut_tv0 (
        .clk(clk), .reset_n(reset_n),
        .instr_valid_i(instr_valid_i), .instr_read_i(instr_read_i),
        .instr_write_i(instr_write_i), .instr_op_i(instr_op_i),
        .instr_addr_i(instr_addr_i), .instr_data_i(instr_data_i),
        .instr_ready_o(rdy0), .instr_rdata_o(rdata0),
        .trap_req_i(trap_req_i), .trap_pc_i(trap_pc_i),
        .trap_cause_i(trap_cause_i), .trap_tval_i(trap_tval_i),
        .trap_ack_o(ack0), .busy_o(busy0),
        .csr_read_o(rd0), .csr_write_o(wr0), .csr_op_o(op0),
        .csr_addr_o(addr0), .csr_data_o(data0), .csr_rdata_i(csr_rdata_i)
    );

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [1:0]  op;
        logic [11:0] addr;
        logic [31:0] data;
        logic        ready;
        logic [31:0] rdata;
        logic        ack;
        logic        busy;
    } obs_t;

    obs_t exp1_q[$], exp0_q[$];     // scoreboard: expected per cycle
    obs_t pend1_q[$], pend0_q[$];   // model: trap writes still to come
    int   compared = 0;
    int   mismatched = 0;
    int   cyc = 0;

    // ---------------- reference model ----------------
    function automatic void pend_push(input int id, input obs_t s);
        if (id == 1) pend1_q.push_back(s);
        else         pend0_q.push_back(s);
    endfunction

    // An accepted trap becomes a fixed list of bank writes for the next cycles.
    function automatic void queue_trap(input int id);
        obs_t s;
        s = '0;
        s.wr = 1'b1; s.op = 2'd1; s.busy = 1'b1;
        s.addr = 12'h341; s.data = trap_pc_i;    pend_push(id, s);
        s.addr = 12'h342; s.data = trap_cause_i; pend_push(id, s);
        if (id == 1) begin
            s.addr = 12'h343; s.data = trap_tval_i; pend_push(id, s);
        end
        s.op = 2'd3; s.addr = 12'h300; s.data = 32'h8; s.ack = 1'b1;
        pend_push(id, s);
    endfunction

    task automatic model(input int id);
        obs_t e;
        bit   has;
        e = '0;
        if (!reset_n) begin
            if (id == 1) pend1_q.delete();
            else         pend0_q.delete();
        end else begin
            has = (id == 1) ? (pend1_q.size() != 0) : (pend0_q.size() != 0);
            if (has) begin
                if (id == 1) e = pend1_q.pop_front();
                else         e = pend0_q.pop_front();
            end else if (trap_req_i) begin
                queue_trap(id);
            end else if (instr_valid_i) begin
                e.ready = 1'b1;
                e.rdata = csr_rdata_i;
                if (instr_read_i || instr_write_i) begin
                    e.rd   = instr_read_i;
                    e.wr   = instr_write_i;
                    e.op   = instr_op_i;
                    e.addr = instr_addr_i;
                    e.data = instr_data_i;
                end
            end
        end
        if (id == 1) exp1_q.push_back(e);
        else         exp0_q.push_back(e);
    endtask

    // ---------------- stimulus helpers ----------------
    // Advance to just after the edge and put idle-but-noisy values on inputs.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        reset_n       = 1'b1;
        trap_req_i    = 1'b0;
        instr_valid_i = 1'b0;
        trap_pc_i     = $urandom;
        trap_cause_i  = $urandom;
        trap_tval_i   = $urandom;
        instr_read_i  = 1'($urandom);
        instr_write_i = 1'($urandom);
        instr_op_i    = 2'($urandom);
        instr_addr_i  = 12'($urandom);
        instr_data_i  = $urandom;
        csr_rdata_i   = $urandom;
    endtask

    task automatic eval();
        model(1);
        model(0);
    endtask

    // ---------------- monitor ----------------
    function automatic void check(input string name, input obs_t a, input obs_t e);
        compared++;
        if (a !== e) begin
            mismatched++;
            $display("FAIL %s cyc=%0d got rd=%b wr=%b op=%0d addr=%h data=%h rdy=%b rdata=%h ack=%b busy=%b | want rd=%b wr=%b op=%0d addr=%h data=%h rdy=%b rdata=%h ack=%b busy=%b",
                     name, cyc, a.rd, a.wr, a.op, a.addr, a.data, a.ready, a.rdata, a.ack, a.busy,
                     e.rd, e.wr, e.op, e.addr, e.data, e.ready, e.rdata, e.ack, e.busy);
        end
    endfunction

    // Sample both instances mid-cycle and compare against the oldest expectation.
    always @(negedge clk) begin : monitor
        obs_t a, e;
        if (exp1_q.size() != 0) begin
            a = '{rd: rd1, wr: wr1, op: op1, addr: addr1, data: data1,
                  ready: rdy1, rdata: rdata1, ack: ack1, busy: busy1};
            e = exp1_q.pop_front();
            check("tval1", a, e);
        end
        if (exp0_q.size() != 0) begin
            a = '{rd: rd0, wr: wr0, op: op0, addr: addr0, data: data0,
                  ready: rdy0, rdata: rdata0, ack: ack0, busy: busy0};
            e = exp0_q.pop_front();
            check("tval0", a, e);
        end
    end

    // ---------------- test sequence ----------------
    initial begin
        // Power-on reset with an instruction request present.
        for (int i = 0; i < 3; i++) begin
            tick(); reset_n = 1'b0; instr_valid_i = 1'b1; trap_req_i = (i == 1); eval();
        end
        tick(); eval();

        // CSRRW 0x340 with bank read data 0x1234.
        tick();
        instr_valid_i = 1'b1; instr_read_i = 1'b1; instr_write_i = 1'b1;
        instr_op_i = 2'd1; instr_addr_i = 12'h340; instr_data_i = 32'hCAFE0001;
        csr_rdata_i = 32'h1234;
        eval();

        // Trap with a competing instruction; trap inputs change after acceptance.
        for (int i = 0; i < 5; i++) begin
            tick(); trap_req_i = 1'b1; instr_valid_i = 1'b1;
            if (i == 0) begin
                trap_pc_i = 32'h80; trap_cause_i = 32'h2; trap_tval_i = 32'hDEAD;
            end
            eval();
        end
        for (int i = 0; i < 6; i++) begin
            tick(); instr_valid_i = 1'b1; eval();
        end

        // Reset while the sequence is in the mcause step.
        tick(); trap_req_i = 1'b1; trap_pc_i = 32'h100; eval();
        tick(); trap_req_i = 1'b1; eval();
        tick(); reset_n = 1'b0; eval();
        for (int i = 0; i < 3; i++) begin
            tick(); instr_valid_i = 1'b1; eval();
        end

        // Request held one cycle past ack: a second sequence follows.
        for (int i = 0; i < 6; i++) begin
            tick(); trap_req_i = 1'b1; eval();
        end
        for (int i = 0; i < 6; i++) begin
            tick(); eval();
        end

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            tick();
            trap_req_i    = ($urandom_range(0, 7) == 0);
            instr_valid_i = 1'($urandom);
            reset_n       = ($urandom_range(0, 199) != 0);
            eval();
        end

        // Drain any trap in flight, then confirm every expectation was consumed.
        for (int i = 0; i < 8; i++) begin
            tick(); eval();
        end
        @(negedge clk);
        #1;
        compared++;
        if (exp1_q.size() != 0 || exp0_q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: got %0d/%0d unchecked expectations, want 0/0",
                     exp1_q.size(), exp0_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
